// File: rtl/srio_pkg.sv
// Shared constants, FSM encoding and header assembly for the UDP to SRIO NWRITE bridge.
package srio_pkg;

  localparam logic [3:0]  FTYPE_NWRITE  = 4'h5;
  localparam logic [3:0]  TTYPE_NWRITE  = 4'h4;
  localparam int unsigned MAX_SEG_BYTES = 256;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_DRAIN
  } state_t;

  // HELLO header beat: tid, ftype, ttype, prio, size-1 and the 34-bit target address.
  function automatic logic [63:0] build_hdr(input logic [7:0]  tid,
                                            input logic [1:0]  prio,
                                            input logic [7:0]  size_m1,
                                            input logic [33:0] addr);
    return {tid, FTYPE_NWRITE, TTYPE_NWRITE, 1'b0, prio, 1'b0, size_m1, 2'b00, addr};
  endfunction

endpackage

// File: rtl/udp_srio_nwrite_if.sv
// Both streams of the bridge: UDP words in, SRIO ireq beats out.
// The slave modport is the bridge itself; master is the surrounding system.
interface udp_srio_nwrite_if;

  logic [31:0] udp_axis_tdata_in;
  logic        udp_axis_tvalid_in;
  logic        udp_axis_tfirst_in;
  logic [3:0]  udp_axis_tkeep_in;
  logic        udp_axis_tlast_in;
  logic [15:0] udp_length_in;
  logic        udp_axis_tready_out;

  logic [63:0] ireq_tdata;
  logic        ireq_tvalid;
  logic [7:0]  ireq_tkeep;
  logic        ireq_tlast;
  logic [31:0] ireq_tuser;
  logic        ireq_tready;

  modport slave (
    input  udp_axis_tdata_in, udp_axis_tvalid_in, udp_axis_tfirst_in,
    input  udp_axis_tkeep_in, udp_axis_tlast_in, udp_length_in,
    output udp_axis_tready_out,
    output ireq_tdata, ireq_tvalid, ireq_tkeep, ireq_tlast, ireq_tuser,
    input  ireq_tready
  );

  modport master (
    output udp_axis_tdata_in, udp_axis_tvalid_in, udp_axis_tfirst_in,
    output udp_axis_tkeep_in, udp_axis_tlast_in, udp_length_in,
    input  udp_axis_tready_out,
    input  ireq_tdata, ireq_tvalid, ireq_tkeep, ireq_tlast, ireq_tuser,
    output ireq_tready
  );

endinterface

// File: rtl/udp_srio_nwrite.sv
// Packs the 32-bit UDP stream into 64-bit SRIO NWRITE requests, splitting each
// packet into segments of at most 256 bytes with their own header beat.
module udp_srio_nwrite
  import srio_pkg::*;
#(
  parameter logic [15:0] SRC_ID    = 16'h0001,
  parameter logic [15:0] DEST_ID   = 16'h00FF,
  parameter logic [33:0] BASE_ADDR = 34'h0,
  parameter logic [1:0]  PRIO      = 2'b01
) (
  input  logic             clk,
  input  logic             reset,
  udp_srio_nwrite_if.slave bus,
  output logic             err_len
);

  localparam logic [8:0] SEG_MAX = 9'(MAX_SEG_BYTES);

  state_t      state;
  logic [16:0] remaining;
  logic [33:0] addr;
  logic [7:0]  tid;
  logic [8:0]  seg_bytes;
  logic [8:0]  seg_cnt;
  logic [31:0] hi;
  logic [3:0]  hi_keep;
  logic        have_hi;

  logic [63:0] out_data;
  logic [7:0]  out_keep;
  logic        out_valid;
  logic        out_last;

  logic        out_free;
  logic        in_ready;
  logic        accept;
  logic [9:0]  cnt_next;
  logic        reached;
  logic        pkt_end;
  logic        seg_done;
  logic [8:0]  hdr_bytes;

  assign out_free = !out_valid || bus.ireq_tready;

  // Ready depends on state and the output register only, never on tvalid.
  always_comb begin
    // NOTE: default first so every path assigns in_ready and no latch is inferred.
    in_ready = 1'b0;
    case (state)
      ST_IDLE:  in_ready = !bus.udp_axis_tfirst_in;
      ST_HDR:   in_ready = 1'b0;
      ST_DATA:  in_ready = out_free;
      ST_DRAIN: in_ready = 1'b1;
      default:  in_ready = 1'b0;
    endcase
  end

  assign accept    = bus.udp_axis_tvalid_in && in_ready;
  assign cnt_next  = {1'b0, seg_cnt} + 10'd4;
  assign reached   = cnt_next >= {1'b0, seg_bytes};
  assign pkt_end   = reached && (remaining == {8'b0, seg_bytes});
  assign seg_done  = reached || bus.udp_axis_tlast_in;
  assign hdr_bytes = (remaining >= 17'(MAX_SEG_BYTES)) ? SEG_MAX : remaining[8:0];

  always_ff @(posedge clk) begin
    // NOTE: non-blocking throughout; the pair buffer and output data are reset too,
    // so nothing stale is visible on ireq after a mid-packet reset.
    if (reset) begin
      state     <= ST_IDLE;
      remaining <= '0;
      addr      <= '0;
      tid       <= '0;
      seg_bytes <= '0;
      seg_cnt   <= '0;
      hi        <= '0;
      hi_keep   <= '0;
      have_hi   <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      err_len   <= 1'b0;
    end else begin
      err_len <= 1'b0;
      if (out_free) out_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (bus.udp_axis_tvalid_in && bus.udp_axis_tfirst_in) begin
            remaining <= {1'b0, bus.udp_length_in} + 17'd1;
            addr      <= BASE_ADDR;
            state     <= ST_HDR;
          end
        end

        ST_HDR: begin
          if (out_free) begin
            out_data  <= build_hdr(tid, PRIO, 8'(hdr_bytes - 9'd1), addr);
            out_keep  <= 8'hFF;
            out_last  <= 1'b0;
            out_valid <= 1'b1;
            seg_bytes <= hdr_bytes;
            seg_cnt   <= '0;
            have_hi   <= 1'b0;
            state     <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (accept) begin
            seg_cnt <= cnt_next[8:0];
            // A beat leaves on the second word of a pair, or early on a segment's final word.
            if (have_hi || seg_done) begin
              out_valid <= 1'b1;
              out_last  <= seg_done;
              have_hi   <= 1'b0;
              if (have_hi) begin
                out_data <= {hi, bus.udp_axis_tdata_in};
                out_keep <= {hi_keep, bus.udp_axis_tkeep_in};
              end else begin
                out_data <= {bus.udp_axis_tdata_in, 32'h0};
                out_keep <= {bus.udp_axis_tkeep_in, 4'h0};
              end
            end else begin
              hi      <= bus.udp_axis_tdata_in;
              hi_keep <= bus.udp_axis_tkeep_in;
              have_hi <= 1'b1;
            end

            if (seg_done) begin
              tid       <= tid + 8'd1;
              addr      <= addr + 34'd256;
              remaining <= remaining - {8'b0, seg_bytes};
              if (bus.udp_axis_tlast_in && !pkt_end) begin
                err_len <= 1'b1;
                state   <= ST_IDLE;
              end else if (pkt_end && !bus.udp_axis_tlast_in) begin
                err_len <= 1'b1;
                state   <= ST_DRAIN;
              end else if (pkt_end) begin
                state <= ST_IDLE;
              end else begin
                state <= ST_HDR;
              end
            end
          end
        end

        ST_DRAIN: begin
          if (accept && bus.udp_axis_tlast_in) state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.udp_axis_tready_out = in_ready;
  assign bus.ireq_tdata          = out_data;
  assign bus.ireq_tvalid         = out_valid;
  assign bus.ireq_tkeep          = out_keep;
  assign bus.ireq_tlast          = out_last;
  assign bus.ireq_tuser          = {SRC_ID, DEST_ID};

endmodule

// File: tb/tb_udp_srio_nwrite.sv
// Scoreboard bench for udp_srio_nwrite: stimulus pushes expected ireq beats,
// a monitor pops and compares every accepted beat.
module tb_udp_srio_nwrite;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        chk_lat;
  } beat_t;

  logic clk = 1'b0;
  logic reset;
  logic err_len;

  udp_srio_nwrite_if bus ();

  udp_srio_nwrite dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .err_len(err_len)
  );

  always #5 clk = ~clk;

  int    n_vec   = 0;
  int    n_miss  = 0;
  int    cyc     = 0;
  int    lat_start = 0;
  int    err_seen = 0;
  int    exp_err  = 0;
  bit    measure_next = 1'b0;
  bit    stall_en = 1'b0;
  bit    hold_rdy = 1'b0;
  logic [7:0] m_tid = 8'd0;
  beat_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] wd(input logic [7:0] seed, input int w);
    logic [7:0] b0;
    b0 = seed + 8'(4 * w);
    return {b0, b0 + 8'd1, b0 + 8'd2, b0 + 8'd3};
  endfunction

  function automatic logic [3:0] kw(input int w, input int nw, input logic [3:0] lk, input bit tl);
    return (tl && w == nw - 1) ? lk : 4'hF;
  endfunction

  // tid | ftype 5 | ttype 4 | 0 | prio 01 | 0 | size-1 | 00 | addr
  function automatic logic [63:0] hdr_word(input logic [7:0] tid, input logic [7:0] sm1, input logic [33:0] a);
    return {tid, 4'h5, 4'h4, 1'b0, 2'b01, 1'b0, sm1, 2'b00, a};
  endfunction

  // Expected beats for a packet of nw words (tl: last word carries tlast).
  task automatic expect_pkt(input int len_f, input int nw, input logic [3:0] lk,
                            input logic [7:0] seed, input bit tl);
    int total_w, used, s, ws, seg_end, we, sbytes;
    bit ended, more;
    beat_t b;
    total_w = (len_f + 4) / 4;
    used    = (nw < total_w) ? nw : total_w;
    if (tl && nw != total_w) exp_err++;
    s = 0;
    do begin
      ws      = 64 * s;
      seg_end = (ws + 64 < total_w) ? ws + 64 : total_w;
      sbytes  = len_f + 1 - 256 * s;
      if (sbytes > 256) sbytes = 256;
      b.data = hdr_word(m_tid, 8'(sbytes - 1), 34'(256 * s));
      b.keep = 8'hFF; b.last = 1'b0; b.chk_lat = (s == 0) && measure_next;
      exp_q.push_back(b);
      we    = (seg_end < used) ? seg_end : used;
      ended = (we == seg_end) || (tl && we == nw);
      for (int w = ws; w < we; w += 2) begin
        b.chk_lat = 1'b0;
        if (w + 1 < we) begin
          b.data = {wd(seed, w), wd(seed, w + 1)};
          b.keep = {kw(w, nw, lk, tl), kw(w + 1, nw, lk, tl)};
          b.last = ended && (w + 2 >= we);
          exp_q.push_back(b);
        end else if (ended) begin
          b.data = {wd(seed, w), 32'h0};
          b.keep = {kw(w, nw, lk, tl), 4'h0};
          b.last = 1'b1;
          exp_q.push_back(b);
        end
      end
      if (ended) m_tid++;
      more = ended && (we == seg_end) && (seg_end < total_w) && !(tl && we == nw);
      s++;
    end while (more);
  endtask

  task automatic drive_word(input logic [31:0] d, input logic [3:0] k, input bit f,
                            input bit l, input logic [15:0] len);
    int n = 0;
    bus.udp_axis_tdata_in  = d;
    bus.udp_axis_tkeep_in  = k;
    bus.udp_axis_tfirst_in = f;
    bus.udp_axis_tlast_in  = l;
    bus.udp_length_in      = len;
    bus.udp_axis_tvalid_in = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.udp_axis_tready_out) break;
      n++;
      if (n > 500) begin
        n_vec++; n_miss++;
        $display("FAIL input_ready_timeout: got no ready in %0d cycles, expected ready", n);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $fatal(1, "input stalled");
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input int len_f, input int nw, input logic [3:0] lk,
                          input logic [7:0] seed, input bit tl);
    expect_pkt(len_f, nw, lk, seed, tl);
    for (int w = 0; w < nw; w++) begin
      if (w == 0 && measure_next) begin
        lat_start    = cyc;
        measure_next = 1'b0;
      end
      drive_word(wd(seed, w), kw(w, nw, lk, tl), w == 0, tl && w == nw - 1, 16'(len_f));
    end
    bus.udp_axis_tvalid_in = 1'b0;
    bus.udp_axis_tfirst_in = 1'b0;
    bus.udp_axis_tlast_in  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check({name, "_drain"}, 64'(exp_q.size()), 64'd0);
    check({name, "_err_len"}, 64'(err_seen), 64'(exp_err));
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #2;
    bus.ireq_tready = hold_rdy ? 1'b0 : (stall_en ? 1'($urandom_range(0, 1)) : 1'b1);
  end

  // Monitor: a beat counts as transferred when valid and ready are both high.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (err_len) err_seen++;
        if (bus.ireq_tvalid && bus.ireq_tready) begin
          if (exp_q.size() == 0) begin
            n_vec++; n_miss++;
            $display("FAIL unexpected_beat: got %h, expected no beat", bus.ireq_tdata);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", bus.ireq_tdata, e.data);
            check("beat_keep", 64'(bus.ireq_tkeep), 64'(e.keep));
            check("beat_last", 64'(bus.ireq_tlast), 64'(e.last));
            if (e.chk_lat) check("hdr_latency", 64'(cyc - lat_start), 64'd2);
          end
        end
      end
    end
  end

  initial begin
    reset                  = 1'b1;
    bus.ireq_tready        = 1'b1;
    bus.udp_axis_tdata_in  = '0;
    bus.udp_axis_tvalid_in = 1'b0;
    bus.udp_axis_tfirst_in = 1'b0;
    bus.udp_axis_tkeep_in  = '0;
    bus.udp_axis_tlast_in  = 1'b0;
    bus.udp_length_in      = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", 64'(bus.ireq_tvalid), 64'd0);
    check("rst_tdata",  bus.ireq_tdata, 64'd0);
    check("rst_tkeep",  64'(bus.ireq_tkeep), 64'd0);
    check("rst_tlast",  64'(bus.ireq_tlast), 64'd0);
    check("rst_err",    64'(err_len), 64'd0);
    check("rst_tuser",  64'(bus.ireq_tuser), 64'h0000_0000_0001_00FF);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;

    measure_next = 1'b1;
    send_pkt(63, 16, 4'hF, 8'h10, 1'b1);     // one 64-byte segment, 8 beats
    wait_drain("len63");
    send_pkt(299, 75, 4'hF, 8'h40, 1'b1);    // 256 + 44 bytes, tids 1 and 2
    wait_drain("len299");
    drive_word(32'hDEAD_BEEF, 4'hF, 1'b0, 1'b1, 16'd0);  // stray word, dropped in IDLE
    bus.udp_axis_tvalid_in = 1'b0;
    send_pkt(12, 4, 4'h8, 8'h80, 1'b1);      // 13 bytes, final keep F8
    wait_drain("len12");

    stall_en = 1'b1;
    send_pkt(1499, 375, 4'hF, 8'hA0, 1'b1);  // 6 segments under random back-pressure
    wait_drain("len1499_stall");
    stall_en = 1'b0;

    send_pkt(63, 5, 4'hF, 8'h33, 1'b1);      // early tlast at word 5
    wait_drain("early_tlast");
    send_pkt(7, 2, 4'hF, 8'h55, 1'b1);
    wait_drain("after_early");
    send_pkt(7, 4, 4'hF, 8'h66, 1'b1);       // count reached before tlast, drain rest
    wait_drain("late_tlast");
    send_pkt(3, 1, 4'hE, 8'hC0, 1'b1);       // single-word packet
    wait_drain("len3");

    // Reset while a beat is held under back-pressure mid-payload.
    send_pkt(255, 20, 4'hF, 8'h77, 1'b0);
    hold_rdy = 1'b1;
    @(negedge clk);
    check("held_tvalid", 64'(bus.ireq_tvalid), 64'd1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_tvalid", 64'(bus.ireq_tvalid), 64'd0);
    check("midrst_tlast",  64'(bus.ireq_tlast), 64'd0);
    check("midrst_tdata",  bus.ireq_tdata, 64'd0);
    exp_q.delete();
    m_tid    = 8'd0;
    hold_rdy = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    send_pkt(7, 2, 4'hF, 8'h90, 1'b1);       // restarts at tid 0
    wait_drain("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/udp_srio_nwrite.md
# udp_srio_nwrite

Converts the 32-bit UDP byte stream (with packet length) into SRIO Gen2 HELLO-format NWRITE requests on a 64-bit initiator request channel. UDP packets longer than 256 bytes are split into 256-byte segments, each with its own header, incrementing address and transaction ID. Sits in the `clk_32` domain between the UDP 8→32 forwarding stage and the SRIO core `ireq` port.

## Interface
- `SRC_ID`, 16'h0001, SRIO source device ID driven on `ireq_tuser[31:16]`
- `DEST_ID`, 16'h00FF, SRIO destination device ID driven on `ireq_tuser[15:0]`
- `BASE_ADDR`, 34'h0, target address of the first segment of every UDP packet
- `PRIO`, 2'b01, priority field in every header
- `clk` in 1: single clock (the 32-bit stream clock)
- `reset` in 1: synchronous, active-high
- `udp_axis_tdata_in` in 32: payload, first byte in [31:24]
- `udp_axis_tvalid_in` in 1: word valid
- `udp_axis_tfirst_in` in 1: first word of packet
- `udp_axis_tkeep_in` in 4: byte valid, bit3 = [31:24]
- `udp_axis_tlast_in` in 1: last word of packet
- `udp_length_in` in 16: packet byte count minus 1, sampled on accepted tfirst word
- `udp_axis_tready_out` out 1: word accepted when high with tvalid
- `ireq_tdata` out 64: header or payload beat, first byte in [63:56]
- `ireq_tvalid` out 1
- `ireq_tkeep` out 8: bit7 = [63:56]
- `ireq_tlast` out 1: last beat of a segment
- `ireq_tuser` out 32: {SRC_ID, DEST_ID}
- `ireq_tready` in 1
- `err_len` out 1: one-cycle pulse on length/tlast mismatch

## Operation
- FSM: IDLE, HDR, DATA, DRAIN.
- IDLE: `udp_axis_tready_out`=0. On `udp_axis_tvalid_in && udp_axis_tfirst_in`: latch `remaining = udp_length_in + 1` (17 bits), `addr = BASE_ADDR`, → HDR. Valid words without tfirst in IDLE are consumed and dropped (ready=1 for them).
- HDR: when output register free, load header beat: `[63:56]`=tid, `[55:52]`=4'h5 (NWRITE ftype), `[51:48]`=4'h4, `[47]`=0, `[46:45]`=PRIO, `[44]`=0, `[43:36]`=seg_bytes−1, `[35:34]`=0, `[33:0]`=addr; tkeep=8'hFF, tlast=0. `seg_bytes = min(remaining, 256)`. → DATA.
- DATA: ready = output register free. First word of a pair held in `hi`; second word forms beat `{hi, word}`. Beat emitted with tlast when seg byte counter reaches seg_bytes; then `remaining -= seg_bytes`, `addr += 256`, `tid += 1` (8-bit wrap), → HDR if remaining>0 else IDLE.
- Odd final word: beat `{word, 32'h0}`, tkeep `{tkeep_in, 4'h0}`. Final tkeep = concatenation of per-word tkeeps.
- Segment boundaries are word-aligned (256 B = 64 words); only the last segment may be partial.
- Early `tlast_in` before count reached: emit pending beat with tlast, pulse `err_len`, → IDLE.
- Count reached without `tlast_in`: emit last beat, pulse `err_len`, → DRAIN; DRAIN holds ready=1, drops words through tlast, → IDLE.
- Output register: standard AXIS; contents stable while `ireq_tvalid && !ireq_tready`. Free = `!ireq_tvalid || ireq_tready`.

## Timing
- Reset: all outputs 0 except `ireq_tuser`={SRC_ID,DEST_ID}; tid=0; state IDLE; `hi` cleared.
- tfirst seen at cycle N → header `ireq_tvalid` at N+2 (IDLE→HDR N+1, load N+2) with ready high throughout.
- Payload: one 64-bit beat per two accepted words; beat valid cycle after second word accepted.
- Ready never asserts in IDLE (except drop) or HDR; no combinational path from `udp_axis_tvalid_in` to `udp_axis_tready_out`.
- Reset mid-segment: output dropped immediately, no tlast issued.

## Structure
- Package `srio_pkg`: FTYPE_NWRITE, TTYPE_NWRITE, MAX_SEG_BYTES=256, state encoding, header-assembly function.
- No sub-module; packer and FSM in one file.

## Test plan
- length_in=63, 16 words → header size 0x3F addr BASE tid 0; 8 beats, last tkeep FF, tlast on 8th.
- length_in=299 → seg0 size 0xFF tid0 addr BASE, 32 beats; seg1 size 0x2B tid1 addr BASE+0x100, 6 beats, last tkeep F0.
- length_in=12, last word tkeep 4'b1000 → size 0x0C, 2 beats, last tkeep F8.
- Random `ireq_tready` stalls over 1500-byte packet → byte-exact payload, no duplicates/losses.
- tlast at word 5 with length_in=63 → beat 3 tlast, `err_len` pulse, next packet header tid correct.
- Reset asserted mid-payload → outputs 0 next cycle, next packet starts at tid 0.
